// File: rtl/imem_responder.sv
// Instruction-memory responder: fetch requests in, in-order instructions out.
// Fixed-latency read pipeline feeding a credit-limited response FIFO.
module imem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW:0]   P_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [CW-1:0] C_MAX = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0]         w_rd_idx;
  logic [AW-1:0]         w_wr_idx;
  logic                  w_err;
  logic                  w_wr_oor;
  logic                  w_acc;
  logic                  w_pop;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_push_v;
  logic [DATA_WIDTH-1:0] w_push_d;
  logic                  w_push_e;
  logic                  w_unused;

  assign w_rd_idx  = req_addr[2 +: AW];
  assign w_wr_idx  = wr_addr[2 +: AW];
  assign w_err     = (|req_addr[1:0]) | (|req_addr[DATA_WIDTH-1:AW+2]);
  assign w_wr_oor  = |wr_addr[DATA_WIDTH-1:AW+2];
  assign w_unused  = ^wr_addr[1:0];
  assign w_rd_data = w_err ? '0 : r_mem[w_rd_idx];
  assign w_acc     = req_valid && req_ready;
  assign w_pop     = resp_valid && resp_ready;

  // Read-before-write: a same-edge accept sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en && !w_wr_oor) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign w_push_v = w_acc;
    assign w_push_d = w_rd_data;
    assign w_push_e = w_err;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0]         r_pv;
    logic [NS-1:0]         r_pe;
    logic [DATA_WIDTH-1:0] r_pd [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_acc;
        for (int i = 1; i < NS; i++) begin
          r_pv[i] <= r_pv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_pd[0] <= w_rd_data;
      r_pe[0] <= w_err;
      for (int i = 1; i < NS; i++) begin
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end

    assign w_push_v = r_pv[NS-1];
    assign w_push_d = r_pd[NS-1];
    assign w_push_e = r_pe[NS-1];
  end

  logic [DATA_WIDTH-1:0] r_fd [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fe;
  logic [PW:0]           r_wp;
  logic [PW:0]           r_rp;
  logic [CW-1:0]         r_out;

  assign w_empty = (r_wp == r_rp);

  // Credit counter covers pipeline and FIFO, so a push never finds it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_out <= '0;
    end else begin
      if (w_push_v) begin
        r_wp <= r_wp + P_ONE;
      end
      if (w_pop) begin
        r_rp <= r_rp + P_ONE;
      end
      if (w_acc && !w_pop) begin
        r_out <= r_out + C_ONE;
      end else if (!w_acc && w_pop) begin
        r_out <= r_out - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_v) begin
      r_fd[r_wp[PW-1:0]] <= w_push_d;
      r_fe[r_wp[PW-1:0]] <= w_push_e;
    end
  end

  assign req_ready  = !rst && (r_out < C_MAX);
  assign resp_valid = !w_empty;
  assign resp_data  = w_empty ? '0 : r_fd[r_rp[PW-1:0]];
  assign resp_err   = !w_empty && r_fe[r_rp[PW-1:0]];

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: random and directed fetches, scoreboard checked
// against a word-array reference model.
module tb_imem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int FD    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  imem_responder #(
    .DATA_WIDTH (DW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] rx [$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rx  = 0;
  int n_err = 0;
  int n_vld = 0;
  int maxo  = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expectation is pushed once the accept edge occurs.
  task automatic cycle(input logic v, input logic [DW-1:0] a,
                       input logic rr, input logic we,
                       input logic [DW-1:0] wa, input logic [DW-1:0] wd,
                       output logic acc);
    logic [DW:0] e;
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    e = '0;
    @(negedge clk);
    acc = v && req_ready && !rst;
    if (acc) begin
      if (a % 4 != 0 || (a / 4) >= DEPTH) e = {1'b1, 32'h0};
      else e = {1'b0, mdl[a / 4]};
    end
    if (we && (wa / 4) < DEPTH) mdl[wa / 4] = wd;
    @(posedge clk);
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rr, 1'b0, '0, '0, acc);
  endtask

  // Monitor: checks credit flow and pops the scoreboard on each handshake.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_q.size() < FD});
        if (exp_q.size() > maxo) maxo = exp_q.size();
        if (resp_valid) n_vld++;
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got 0x%08h expected none", resp_data);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", resp_data, e[DW-1:0]);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e[DW]});
          end
          rx.push_back(resp_data);
          n_rx++;
          if (resp_err) n_err++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int nacc;
    int r0;
    int e0;
    int v0;
    int cnt;
    logic [DW-1:0] a;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      a = (k < 16) ? 32'h1000_0000 + k : $urandom;
      cycle(1'b0, '0, 1'b1, 1'b1, k * 4, a, acc);
    end

    // Back-to-back stream, latency and throughput.
    nacc = 0;
    r0 = n_rx;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, k * 4, 1'b1, 1'b0, '0, '0, acc);
      nacc += int'(acc);
      if (k == LAT - 2) chk("lat_early", {31'b0, resp_valid}, 32'h0);
      if (k == LAT - 1) chk("lat_first", {31'b0, resp_valid}, 32'h1);
    end
    idle(LAT, 1'b1);
    chk("stream_accepts", nacc, 16);
    chk("stream_no_bubble", n_rx - r0, 16);
    chk("stream_first", rx[r0], 32'h1000_0000);
    chk("stream_last", rx[r0+15], 32'h1000_000F);
    idle(3, 1'b1);

    // Backpressure: credits run out at FD.
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, {20'b0, 10'($urandom), 2'b00}, 1'b0, 1'b0, '0, '0, acc);
      nacc += int'(acc);
    end
    chk("bp_accepts", nacc, FD);
    chk("bp_ready_low", {31'b0, req_ready}, 32'h0);
    cycle(1'b1, 32'h4, 1'b1, 1'b0, '0, '0, acc);
    nacc = int'(acc);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, acc);
      nacc += int'(acc);
    end
    chk("bp_one_more", nacc, 1);
    idle(10, 1'b1);
    chk("bp_drained", exp_q.size(), 0);

    // Error responses interleaved with good ones.
    r0 = n_rx;
    e0 = n_err;
    cycle(1'b1, 32'h4, 1'b1, 1'b0, '0, '0, acc);
    cycle(1'b1, 32'h2, 1'b1, 1'b0, '0, '0, acc);
    cycle(1'b1, 32'h8, 1'b1, 1'b0, '0, '0, acc);
    cycle(1'b1, 32'h1000, 1'b1, 1'b0, '0, '0, acc);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, '0, '0, acc);
    idle(LAT + 3, 1'b1);
    chk("err_count", n_err - e0, 2);
    chk("err_data0", rx[r0+1], 32'h0);
    chk("err_neigh", rx[r0+2], 32'h1000_0002);
    chk("err_after", rx[r0+4], 32'h1000_0003);

    // Same-edge write and accept returns the old word.
    r0 = n_rx;
    cycle(1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, acc);
    cycle(1'b1, 32'h8, 1'b1, 1'b0, '0, '0, acc);
    idle(LAT + 3, 1'b1);
    chk("wr_old", rx[r0], 32'h1000_0002);
    chk("wr_new", rx[r0+1], 32'hDEAD_BEEF);

    // Asynchronous reset with responses in flight.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h10 + k * 4, 1'b0, 1'b0, '0, '0, acc);
    end
    #3;
    req_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'h0);
    chk("arst_resp_data", resp_data, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    r0 = n_rx;
    v0 = n_vld;
    idle(6, 1'b1);
    chk("arst_no_stale", n_rx - r0, 0);
    chk("arst_no_valid", n_vld - v0, 0);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, '0, '0, acc);
    cycle(1'b1, 32'h3C, 1'b1, 1'b0, '0, '0, acc);
    idle(LAT + 3, 1'b1);
    chk("arst_keep0", rx[r0], 32'h1000_0000);
    chk("arst_keep15", rx[r0+1], 32'h1000_000F);

    // Random traffic with random backpressure and back-door writes.
    cnt = 0;
    for (int c = 0; c < 4000 && cnt < 200; c++) begin
      cycle(($urandom % 4) != 0, {20'b0, 10'($urandom), 2'b00},
            1'($urandom), ($urandom % 10) == 0,
            {20'b0, 10'($urandom), 2'b00}, $urandom, acc);
      if (acc && req_valid) cnt++;
    end
    chk("rand_accepts", cnt, 200);
    idle(20, 1'b1);
    chk("rand_drained", exp_q.size(), 0);
    n_cmp++;
    if (maxo > FD) begin
      n_bad++;
      $display("FAIL max_outstanding: got %0d expected <= %0d", maxo, FD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the PC/IF stage.
- Accepts word-aligned fetch addresses over a valid/ready request channel and reads a synchronous instruction array through a fixed-latency read pipeline.
- Returns instructions in order over a valid/ready response channel, through a small response FIFO.
- A back-door write port preloads program images from benches and the boot loader.

Parameters:
- DATA_WIDTH, 32, width of address, instruction and write data.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, accept-to-response cycles through the read pipeline; legal 1..4.
- FIFO_DEPTH, 4, response FIFO entries; also the maximum number of outstanding requests; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  DATA_WIDTH  byte address of the fetch.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_WIDTH  fetched instruction.
- resp_err  out  1  fetch error flag for this response.
- wr_en  in  1  back-door write enable.
- wr_addr  in  DATA_WIDTH  back-door byte address; word index is wr_addr[2 +: log2(DEPTH_WORDS)].
- wr_data  in  DATA_WIDTH  back-door write data.

Behaviour:
- Reset (asynchronous assert, synchronous deassert as seen by logic):
  - All pipeline valid bits, FIFO pointers and the outstanding counter clear to 0.
  - resp_valid=0, resp_data=0, resp_err=0.
  - req_ready=0 while rst=1.
  - Array contents are NOT reset.
  - Reset mid-operation discards all in-flight and queued responses; no stale response may appear after reset.
- Request accept: req_valid && req_ready at a rising edge.
  - The array word is read at that edge and captured into pipeline stage 1.
  - req_addr is don't-care when req_valid=0.
- Error check at accept:
  - resp_err=1 if req_addr[1:0]!=0 or word index (req_addr>>2) >= DEPTH_WORDS.
  - Error responses carry resp_data=0 and still consume a slot; ordering is preserved.
- Latency: a request accepted at edge N enters the FIFO at edge N+LATENCY-1. With the FIFO previously empty, resp_valid=1 in the cycle after edge N+LATENCY-1.
  - LATENCY=1: response visible in the cycle immediately after the accept edge.
- Response handshake:
  - resp_data and resp_err are stable and resp_valid stays high until resp_valid && resp_ready.
  - The FIFO pops on that edge; when the FIFO is empty, resp_valid=0.
  - Responses are strictly in request order.
- Credit/backpressure:
  - outstanding = entries in pipeline + FIFO; counter width clog2(FIFO_DEPTH+1).
  - req_ready = !rst && (outstanding < FIFO_DEPTH). It is combinational from registered state only and never depends on req_valid.
  - Accept and pop on the same edge leave outstanding unchanged.
  - The FIFO can never overflow; no drop path exists.
- Back-door write: wr_en writes wr_data to the word index at the rising edge.
  - Out-of-range wr_addr is ignored.
  - A same-edge write and accept to the same word returns the OLD data.
  - A request accepted on any later edge returns the new data.
- Full throughput: with resp_ready held at 1, one request is accepted and one response delivered per cycle, with no bubbles.

Test Plan:
- Preload word k = 0x1000_0000+k for k=0..15. Issue req_addr=0,4,...,60 back-to-back with resp_ready=1 -> 16 responses in order, data 0x1000_0000..0x1000_000F, resp_err=0, first resp_valid LATENCY cycles after the first accept, one per cycle thereafter.
- Hold resp_ready=0 and issue continuous requests -> exactly FIFO_DEPTH (4) accepted, then req_ready=0. Raise resp_ready for one cycle -> one pop, req_ready returns 1, exactly one further accept.
- req_addr=0x2 and req_addr=4*DEPTH_WORDS (0x1000) -> each response has resp_err=1, resp_data=0. A neighbouring valid request keeps correct data and order.
- wr_en with wr_addr=0x8, wr_data=0xDEADBEEF on the same edge as an accept of 0x8 -> old word returned. An accept of 0x8 on the next edge -> 0xDEADBEEF.
- Assert rst with 3 requests outstanding -> resp_valid=0 and req_ready=0 immediately (asynchronous). After release, no responses appear until new requests are accepted, and array contents are preserved.
- Random resp_ready (50%) over 200 random aligned in-range requests -> scoreboard matches every response in order, and outstanding never exceeds 4.
